coll_reduce_engine: RTL and testbench
=====================================

Name: coll_reduce_engine

Overview:
- Parametrised multi-slot reduction engine for the MPI collective router.
- Accepts per-rank contributions tagged with a collective index and accumulates them with the selected reduction op.
- Up to SLOTS collectives can be in flight at once.
- When commsize contributions for an index have arrived, emits one 64-bit result packet toward the router output stage.

Parameters:
- DATA_W, 32, contribution/accumulator width (8..32)
- RANK_W, 3, width of src/rank/root fields; MAX_RANKS = 2**RANK_W
- IDX_W, 4, collective index width
- SLOTS, 4, concurrent in-flight collectives (1..8)
- TIMEOUT_CYC, 255, partial-flush age limit (used only with COLL_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- dataIn  in  DATA_W  contribution value
- src  in  RANK_W  contributing rank
- rank  in  RANK_W  local rank, copied into packet
- root  in  RANK_W  collective root, copied into packet
- op  in  5  reduction op code
- commsize  in  RANK_W+1  number of contributions required
- index  in  IDX_W  collective tag
- in_valid  in  1  contribution present
- in_ready  out  1  engine can accept
- Outpacket  out  64  result packet
- out_valid  out  1  Outpacket valid
- out_ready  in  1  downstream accepts
- done  out  1  one-cycle pulse on each packet handshake
- err  out  1  one-cycle pulse when a contribution is dropped

Behaviour:
- Reset: all slots invalid; out_valid=0, Outpacket=0, done=0, err=0, in_ready=0 during the reset cycle. Reset mid-operation discards all partial accumulations and any pending packet.
- Acceptance: a contribution is accepted on in_valid && in_ready.
- in_ready = !rst && !(out_valid && !out_ready) && (some valid slot tag == index || some slot free).
- Slot state: valid, tag, op, commsize, accumulator, seen mask (MAX_RANKS bits), count.
- Accept, hit on a valid slot with tag == index:
  - If seen[src] is already set, or op differs from the slot's latched op: drop, err=1 next cycle, slot unchanged.
  - Otherwise acc = f(acc, dataIn), seen[src]=1, count+1.
- Accept, miss: allocate the lowest-numbered free slot; acc = dataIn, count=1; latch op and commsize.
- Drop conditions, each with err pulse and no slot allocated:
  - op not in the supported set
  - commsize == 0
  - commsize > MAX_RANKS
- Ops:
  - 0 SUM, wraps mod 2**DATA_W
  - 1 MAX unsigned
  - 2 MIN unsigned
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6..31 invalid
- Completion: when the updated count equals commsize (including commsize==1 on allocate), the result is loaded into Outpacket and out_valid=1 on the next clock; the slot is freed in the same edge.
- Output latency: 1 cycle from the completing accept to out_valid.
- Outpacket layout:
  - [63:61] rank
  - [60:58] root
  - [57:53] op
  - [52:49] index
  - [48:45] count
  - [44] timeout flag
  - [43:32] zero
  - [31:0] result, zero-extended
- Fields narrower than their packet slots are zero-extended.
- Output handshake: Outpacket and out_valid hold until out_valid && out_ready; done=1 in the cycle after that handshake.
- Simultaneous events: accept and output handshake may occur in the same cycle. A completing accept is blocked while out_valid && !out_ready, so no packet is ever overwritten.
- Full: all slots valid and index misses -> in_ready=0, no drop, no err.
- Tag reuse: an index may be reused immediately after its slot frees.

Optional Feature:
- Macro: COLL_TIMEOUT_EN.
- Defined:
  - Each valid slot carries an age counter, cleared on allocate and on every accepted contribution.
  - When age reaches TIMEOUT_CYC and the output register is free, the partial result is emitted with bit[44]=1 and count = contributions received, and the slot is freed.
  - On a same-cycle tie, completion has priority over timeout; among multiple timed-out slots, the lowest slot number wins.
- Undefined: no age counters; slots wait indefinitely; bit[44] is always 0.

Test Plan:
- SUM: index=1, commsize=3, op=0, src 0/1/2 with data 6/5/4, out_ready=1 -> one packet, [31:0]=15, count=3, index=1; done pulses once.
- Interleaved: index 1 and 0, op=1 (MAX), commsize=2, data 6,2 (idx1) and 3,1 (idx0) in alternating cycles -> packets with 6 (idx1) then 3 (idx0), in completion order.
- Duplicate and invalid: src=1 contributes twice to index 2 -> err pulse, count stays 1. op=9 -> err, no slot allocated.
- Full and backpressure: SLOTS=4 partial indices plus a 5th index -> in_ready=0. Completing packet with out_ready=0 for 5 cycles -> Outpacket stable, in_ready=0 for completing traffic.
- Reset and wrap: rst mid-accumulation -> no packet afterwards, slots free. SUM of 0xFFFFFFFF and 2 -> result 1.
- COLL_TIMEOUT_EN, TIMEOUT_CYC=8: one contribution (data 7) to commsize=3, then idle -> packet with bit44=1, count=1, result 7.

Source files
------------

// File: rtl/coll_reduce_engine.sv
// coll_reduce_engine: multi-slot reduction engine that folds per-rank MPI contributions into one 64-bit result packet.
// Optional build macro COLL_TIMEOUT_EN: flushes stale partial slots after TIMEOUT_CYC idle cycles (bit 44 marks them).
module coll_reduce_engine #(
    parameter int DATA_W      = 32,
    parameter int RANK_W      = 3,
    parameter int IDX_W       = 4,
    parameter int SLOTS       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [RANK_W-1:0] src,
    input  logic [RANK_W-1:0] rank,
    input  logic [RANK_W-1:0] root,
    input  logic [4:0]        op,
    input  logic [RANK_W:0]   commsize,
    input  logic [IDX_W-1:0]  index,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [63:0]       Outpacket,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              err
);

    localparam int MAX_RANKS = 1 << RANK_W;
    localparam int CNT_W     = RANK_W + 1;
    localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [SLOTS-1:0]     s_valid;
    logic [IDX_W-1:0]     s_tag  [SLOTS];
    logic [4:0]           s_op   [SLOTS];
    logic [CNT_W-1:0]     s_size [SLOTS];
    logic [DATA_W-1:0]    s_acc  [SLOTS];
    logic [MAX_RANKS-1:0] s_seen [SLOTS];
    logic [CNT_W-1:0]     s_cnt  [SLOTS];

    logic              hit;
    logic [SLOT_W-1:0] hit_slot;
    logic              free_any;
    logic [SLOT_W-1:0] free_slot;
    logic              out_stall;
    logic              accept;
    logic              op_ok;
    logic              size_ok;
    logic              hit_bad;
    logic              drop;
    logic              upd;
    logic [DATA_W-1:0] new_acc;
    logic [CNT_W-1:0]  new_cnt;
    logic              complete;

    function automatic logic [DATA_W-1:0] reduce(input logic [4:0] f_op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (f_op)
            5'd0:    reduce = a + b;
            5'd1:    reduce = (a > b) ? a : b;
            5'd2:    reduce = (a < b) ? a : b;
            5'd3:    reduce = a & b;
            5'd4:    reduce = a | b;
            5'd5:    reduce = a ^ b;
            default: reduce = a;
        endcase
    endfunction

    function automatic logic [63:0] pack(input logic [RANK_W-1:0] p_rank,
                                         input logic [RANK_W-1:0] p_root,
                                         input logic [4:0]        p_op,
                                         input logic [IDX_W-1:0]  p_idx,
                                         input logic [CNT_W-1:0]  p_cnt,
                                         input logic              p_to,
                                         input logic [DATA_W-1:0] p_res);
        logic [63:0] p;
        p        = '0;
        p[63:61] = 3'(p_rank);
        p[60:58] = 3'(p_root);
        p[57:53] = p_op;
        p[52:49] = 4'(p_idx);
        p[48:45] = 4'(p_cnt);
        p[44]    = p_to;
        p[31:0]  = 32'(p_res);
        return p;
    endfunction

    // Tags are unique among valid slots, so at most one slot can hit.
    always_comb begin
        hit       = 1'b0;
        hit_slot  = '0;
        free_any  = 1'b0;
        free_slot = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (s_valid[i] && s_tag[i] == index) begin
                hit      = 1'b1;
                hit_slot = SLOT_W'(i);
            end
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!s_valid[i]) begin
                free_any  = 1'b1;
                free_slot = SLOT_W'(i);
            end
        end
    end

    assign out_stall = out_valid && !out_ready;
    assign in_ready  = !rst && !out_stall && (hit || free_any);
    assign accept    = in_valid && in_ready;
    assign op_ok     = op <= 5'd5;
    assign size_ok   = (commsize != '0) && (commsize <= CNT_W'(MAX_RANKS));
    assign hit_bad   = s_seen[hit_slot][src] || (s_op[hit_slot] != op);
    assign drop      = accept && (hit ? hit_bad : !(op_ok && size_ok));
    assign upd       = accept && !drop;
    assign new_acc   = hit ? reduce(s_op[hit_slot], s_acc[hit_slot], dataIn) : dataIn;
    assign new_cnt   = hit ? s_cnt[hit_slot] + CNT_W'(1) : CNT_W'(1);
    assign complete  = upd && (new_cnt == (hit ? s_size[hit_slot] : commsize));

`ifdef COLL_TIMEOUT_EN
    localparam int AGE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [AGE_W-1:0]  s_age [SLOTS];
    logic              to_fire;
    logic [SLOT_W-1:0] to_slot;

    // A slot being refreshed this cycle is not stale; completions own the output register.
    always_comb begin
        to_fire = 1'b0;
        to_slot = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (s_valid[i] && s_age[i] >= AGE_W'(TIMEOUT_CYC) &&
                !(upd && hit && hit_slot == SLOT_W'(i))) begin
                to_fire = 1'b1;
                to_slot = SLOT_W'(i);
            end
        end
        if (complete || out_stall) to_fire = 1'b0;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYC[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Outpacket <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            s_valid   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                s_tag[i]  <= '0;
                s_op[i]   <= '0;
                s_size[i] <= '0;
                s_acc[i]  <= '0;
                s_seen[i] <= '0;
                s_cnt[i]  <= '0;
`ifdef COLL_TIMEOUT_EN
                s_age[i]  <= '0;
`endif
            end
        end else begin
            done <= out_valid && out_ready;
            err  <= drop;
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (upd) begin
                if (complete) begin
                    out_valid <= 1'b1;
                    Outpacket <= pack(rank, root, op, index, new_cnt, 1'b0, new_acc);
                    if (hit) s_valid[hit_slot] <= 1'b0;
                end else if (hit) begin
                    s_acc[hit_slot]       <= new_acc;
                    s_seen[hit_slot][src] <= 1'b1;
                    s_cnt[hit_slot]       <= new_cnt;
                end else begin
                    s_valid[free_slot] <= 1'b1;
                    s_tag[free_slot]   <= index;
                    s_op[free_slot]    <= op;
                    s_size[free_slot]  <= commsize;
                    s_acc[free_slot]   <= dataIn;
                    s_seen[free_slot]  <= MAX_RANKS'(1) << src;
                    s_cnt[free_slot]   <= CNT_W'(1);
                end
            end

`ifdef COLL_TIMEOUT_EN
            for (int i = 0; i < SLOTS; i++) begin
                if (s_valid[i] && s_age[i] < AGE_W'(TIMEOUT_CYC)) s_age[i] <= s_age[i] + AGE_W'(1);
            end
            if (upd && !complete) s_age[hit ? hit_slot : free_slot] <= '0;
            if (to_fire) begin
                out_valid        <= 1'b1;
                Outpacket        <= pack(rank, root, s_op[to_slot], s_tag[to_slot],
                                         s_cnt[to_slot], 1'b1, s_acc[to_slot]);
                s_valid[to_slot] <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_coll_reduce_engine.sv
// Self-checking bench for coll_reduce_engine: per-index behavioural model plus directed literal checks and random traffic.
`timescale 1ns/1ps
module tb_coll_reduce_engine;

    localparam int DATA_W = 32;
    localparam int RANK_W = 3;
    localparam int IDX_W  = 4;
    localparam int SLOTS  = 4;
`ifdef COLL_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] dataIn;
    logic [RANK_W-1:0] src, rank, root;
    logic [4:0]        op;
    logic [RANK_W:0]   commsize;
    logic [IDX_W-1:0]  index;
    logic              in_valid, in_ready, out_valid, out_ready, done, err;
    logic [63:0]       Outpacket;

    always #5 clk = ~clk;

    coll_reduce_engine #(
        .DATA_W(DATA_W), .RANK_W(RANK_W), .IDX_W(IDX_W), .SLOTS(SLOTS), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .src(src), .rank(rank), .root(root),
        .op(op), .commsize(commsize), .index(index), .in_valid(in_valid), .in_ready(in_ready),
        .Outpacket(Outpacket), .out_valid(out_valid), .out_ready(out_ready), .done(done), .err(err)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: one record per collective index, plus the single output register.
    bit          m_act  [16];
    logic [4:0]  m_op   [16];
    int          m_size [16];
    logic [31:0] m_acc  [16];
    logic [7:0]  m_seen [16];
    int          m_cnt  [16];
    int          m_nact;
    bit          m_ov, m_done, m_err;
    logic [63:0] m_pkt;

    logic [63:0] pkt_q[$];
    int          n_done = 0;
    int          n_err = 0;
    logic [4:0]  rop[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_act[i] = 0; m_op[i] = '0; m_size[i] = 0; m_acc[i] = '0; m_seen[i] = '0; m_cnt[i] = 0;
        end
        m_nact = 0; m_ov = 0; m_done = 0; m_err = 0; m_pkt = '0;
    endtask

    function automatic logic [31:0] red(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            5'd0:    return a + b;
            5'd1:    return (a > b) ? a : b;
            5'd2:    return (a < b) ? a : b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic emit(input logic [4:0] o, input logic [3:0] ix, input int cnt, input logic [31:0] res);
        m_ov  = 1;
        m_pkt = {rank, root, o, ix, 4'(cnt), 1'b0, 12'd0, res};
    endtask

    function automatic bit model_ready();
        return !rst && !(m_ov && !out_ready) && (m_act[index] || m_nact < SLOTS);
    endfunction

    task automatic model_advance(input bit rdy);
        bit nd, ne;
        int ix;
        if (rst) begin
            model_clear();
            return;
        end
        nd = m_ov && out_ready;
        ne = 0;
        if (m_ov && out_ready) m_ov = 0;
        if (in_valid && rdy) begin
            ix = int'(index);
            if (m_act[ix]) begin
                if (m_seen[ix][src] || op != m_op[ix]) ne = 1;
                else begin
                    m_acc[ix] = red(m_op[ix], m_acc[ix], dataIn);
                    m_seen[ix][src] = 1'b1;
                    m_cnt[ix]++;
                    if (m_cnt[ix] == m_size[ix]) begin
                        emit(m_op[ix], index, m_cnt[ix], m_acc[ix]);
                        m_act[ix] = 0;
                        m_nact--;
                    end
                end
            end else if (op > 5'd5 || commsize == 0 || commsize > 8) begin
                ne = 1;
            end else if (commsize == 1) begin
                emit(op, index, 1, dataIn);
            end else begin
                m_act[ix] = 1; m_op[ix] = op; m_size[ix] = int'(commsize);
                m_acc[ix] = dataIn; m_seen[ix] = 8'd1 << src; m_cnt[ix] = 1;
                m_nact++;
            end
        end
        m_done = nd;
        m_err  = ne;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        bit rdy;
        #1;
        rdy = model_ready();
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
        if (m_ov) chk("Outpacket", Outpacket, m_pkt);
        if (out_valid === 1'b1 && out_ready) pkt_q.push_back(Outpacket);
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;
        model_advance(rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int ix, input int s, input logic [31:0] d, input int o, input int cs);
        in_valid = 1; index = 4'(ix); src = 3'(s); dataIn = d; op = 5'(o); commsize = 4'(cs);
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0;
        step(); step();
        rst = 0;
    endtask

    logic [63:0] held, tpkt;
    int          e0, n0, r;
    bit          seen;

    initial begin
        rst = 1; in_valid = 0; index = '0; src = '0; dataIn = '0; op = '0; commsize = '0;
        rank = 3'd5; root = 3'd2; out_ready = 1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_Outpacket", Outpacket, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        step(); step();
        rst = 0;

`ifdef COLL_TIMEOUT_EN
        in_valid = 1; index = 4'd6; src = 3'd0; dataIn = 32'd7; op = 5'd0; commsize = 4'd3;
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            #1;
            if (out_valid) begin seen = 1; tpkt = Outpacket; end
            else begin @(posedge clk); @(negedge clk); end
        end
        chk("to_seen", 64'(seen), 64'd1);
        chk("to_flag", 64'(tpkt[44]), 64'd1);
        chk("to_count", 64'(tpkt[48:45]), 64'd1);
        chk("to_result", 64'(tpkt[31:0]), 64'd7);
        chk("to_index", 64'(tpkt[52:49]), 64'd6);
`else
        // SUM of 6+5+4 on index 1
        drive(1, 0, 6, 0, 3); drive(1, 1, 5, 0, 3); drive(1, 2, 4, 0, 3); idle(3);
        chk("sum_pkts", 64'(pkt_q.size()), 64'd1);
        chk("sum_pkt", (pkt_q.size() > 0) ? pkt_q[0] : 64'd0, 64'hA802_6000_0000_000F);
        chk("sum_done", 64'(n_done), 64'd1);

        // Interleaved MAX on indices 1 and 0
        pkt_q.delete();
        drive(1, 0, 6, 1, 2); drive(0, 0, 3, 1, 2); drive(1, 1, 2, 1, 2); drive(0, 1, 1, 1, 2); idle(3);
        chk("ilv_pkts", 64'(pkt_q.size()), 64'd2);
        chk("ilv_first_res", (pkt_q.size() > 0) ? 64'(pkt_q[0][31:0]) : 64'hX, 64'd6);
        chk("ilv_first_idx", (pkt_q.size() > 0) ? 64'(pkt_q[0][52:49]) : 64'hX, 64'd1);
        chk("ilv_second_pkt", (pkt_q.size() > 1) ? pkt_q[1] : 64'd0, 64'hA820_4000_0000_0003);

        // Duplicate source and unsupported op
        pkt_q.delete();
        e0 = n_err;
        drive(2, 1, 5, 0, 3); drive(2, 1, 9, 0, 3); drive(2, 0, 1, 0, 3); drive(2, 2, 2, 0, 3); idle(3);
        chk("dup_err", 64'(n_err - e0), 64'd1);
        chk("dup_res", (pkt_q.size() > 0) ? 64'(pkt_q[0][31:0]) : 64'hX, 64'd8);
        chk("dup_cnt", (pkt_q.size() > 0) ? 64'(pkt_q[0][48:45]) : 64'hX, 64'd3);
        drive(5, 0, 1, 9, 2); idle(2);
        chk("badop_err", 64'(n_err - e0), 64'd2);

        // Four partial indices fill every slot; a fifth index must stall without error
        drive(8, 0, 0, 0, 3); drive(9, 0, 10, 0, 3); drive(10, 0, 20, 0, 3); drive(11, 0, 30, 0, 3);
        e0 = n_err;
        in_valid = 1; index = 4'd12; src = 3'd0; dataIn = 32'd1; op = 5'd0; commsize = 4'd3;
        #1 chk("full_ready", 64'(in_ready), 64'd0);
        step(); idle(1);
        chk("full_noerr", 64'(n_err - e0), 64'd0);

        // Backpressure on a finished packet
        out_ready = 0;
        drive(8, 1, 1, 0, 3); drive(8, 2, 2, 0, 3);
        in_valid = 1; index = 4'd9; src = 3'd1; dataIn = 32'd5; op = 5'd0; commsize = 4'd3;
        #1 held = Outpacket;
        chk("bp_result", 64'(held[31:0]), 64'd3);
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready", 64'(in_ready), 64'd0);
            step();
            #1;
            chk("bp_hold", Outpacket, held);
        end
        out_ready = 1;
        step();
        idle(2);
        do_reset();

        // Reset in the middle of an accumulation discards it
        n0 = pkt_q.size();
        drive(4, 0, 1, 0, 3);
        rst = 1; in_valid = 0; step(); rst = 0;
        drive(4, 1, 2, 0, 3); drive(4, 2, 3, 0, 3); idle(4);
        chk("rst_nopkt", 64'(pkt_q.size() - n0), 64'd0);
        do_reset();

        // SUM wraps modulo 2**32
        drive(3, 0, 32'hFFFF_FFFF, 0, 2); drive(3, 1, 2, 0, 2); idle(2);
        chk("wrap_res", (pkt_q.size() > 0) ? 64'(pkt_q[$][31:0]) : 64'hX, 64'd1);
        chk("wrap_cnt", (pkt_q.size() > 0) ? 64'(pkt_q[$][48:45]) : 64'hX, 64'd2);

        // Random traffic against the model
        for (int i = 0; i < 6; i++) rop[i] = 5'($urandom_range(0, 5));
        for (int c = 0; c < 4000; c++) begin
            int ix;
            ix        = $urandom_range(0, 5);
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            index     = 4'(ix);
            src       = 3'($urandom_range(0, 7));
            dataIn    = $urandom();
            op        = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : rop[ix];
            r         = $urandom_range(0, 19);
            commsize  = (r == 0) ? 4'd0 : (r == 1) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 4));
            step();
        end
        rst = 0; out_ready = 1;
        idle(3);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
